matrix_mult_stream_ctrl: RTL
============================

Name: matrix_mult_stream_ctrl

Overview:
Element-serial front/back end for the matrix_mult datapath. Accepts A then B one element per handshake on an input stream and packs them into flat operand buses. Sequences the multiplier through reset, enable and rdy, captures the flat result C and streams it back out one element per handshake. Sits between a host/DMA stream and one matrix_mult instance.

Parameters:
ORDER, 2, matrix dimension N (N x N operands and result)
BITWIDTH, 8, element width in bits, signed two's complement
TIMEOUT, 4096, max cycles in RUN waiting for mm_rdy before abort (must exceed ORDER^3+2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input element valid
s_ready  out  1  input element accepted when s_valid&s_ready
s_data  in  BITWIDTH  input element; first N^2 = A row-major, next N^2 = B row-major
m_valid  out  1  result element valid
m_ready  in  1  downstream accepts result element
m_data  out  BITWIDTH  result element C[i][j], row-major order
m_last  out  1  high with final element C[N-1][N-1]
mm_reset  out  1  active-high reset to matrix_mult
mm_enable  out  1  enable to matrix_mult
mm_a  out  N*N*BITWIDTH  flat A; element (i,j) at lane i*N+j
mm_b  out  N*N*BITWIDTH  flat B, same packing
mm_c  in  N*N*BITWIDTH  flat C from matrix_mult, same packing
mm_rdy  in  1  matrix_mult result valid
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset_n low, async): state LOAD_A, counters 0, s_ready=0, m_valid=0, m_last=0, m_data=0, mm_reset=1, mm_enable=0, mm_a/mm_b/result reg=0, err=0. s_ready rises on first clock after release.
- All outputs registered. mm_reset=1 in every state except RUN; mm_enable=1 only in RUN.
- LOAD_A: s_ready=1; each handshake writes s_data to mm_a lane idx, idx++; on lane N^2-1 -> LOAD_B, idx=0.
- LOAD_B: same into mm_b; on lane N^2-1 -> RUN, s_ready=0 from next cycle; wait counter=0.
- RUN: mm_reset=0, mm_enable=1. Multiplier needs ORDER^3+2 enabled cycles; rdy appears then. When mm_rdy=1: capture mm_c into result reg, -> DRAIN, mm_enable=0, mm_reset=1 next cycle.
- RUN timeout: wait counter reaches TIMEOUT-1 without mm_rdy -> err=1 (sticky until reset), discard job, -> LOAD_A, no output produced.
- DRAIN: m_valid=1, m_data=result lane odx. m_data/m_last held stable while m_valid&!m_ready. Handshake -> odx++; m_last=1 when odx=N^2-1; handshake on last -> LOAD_A, m_valid=0, s_ready=1 next cycle.
- No overlap: s_ready=0 during RUN and DRAIN; s_valid ignored there.
- Result elements are the multiplier's lower BITWIDTH bits; no saturation. Controller does no arithmetic.
- Index counters $clog2(N*N) bits (min 1). Wrap to 0 only via state transitions.
- Simultaneous mm_rdy and timeout on the same cycle: mm_rdy wins, no err.
- reset_n low mid-job: abort immediately; partial A/B and result discarded; mm_reset=1 holds multiplier cleared.
- Throughput: 2N^2 load cycles + 1 + (ORDER^3+2) + N^2 drain cycles at full handshake rate.

Decomposition:
- Shared package mm_pkg: state enum (LOAD_A, LOAD_B, RUN, DRAIN), lane index helper function, localparams for N*N and flat width.
- No sub-module; single FSM plus two pack/unpack counters. Bench instantiates it with a real matrix_mult.

Test Plan:
- ORDER=2, stream A=[1,2,3,4], B=[5,6,7,8], m_ready=1 -> m_data 19,22,43,50, m_last on 50, err=0.
- Signed: A=[-1,2,3,-4], B=identity -> output 0xFF,0x02,0x03,0xFC.
- Wrap: A=[100,100,0,0], B=[2,0,2,0] -> C[0][0]=8'h90, others 0.
- Backpressure: random s_valid gaps and m_ready toggling 50% -> same results as case 1, m_data stable while stalled, no dropped or duplicated element.
- Timeout: mm_rdy tied 0, TIMEOUT=16, load case 1 -> err=1 after 16 RUN cycles, m_valid never asserts, s_ready=1 again; next job with real multiplier still completes correctly, err stays 1.
- Reset mid-DRAIN after 2 outputs -> m_valid=0, mm_reset=1 immediately; fresh job afterwards yields 19,22,43,50.

Source files
------------

// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared types and helpers for the matrix_mult stream controller.
//   state_t    : controller phases (load A, load B, run multiplier, drain C)
//   MM_*       : default matrix order / element width and derived sizes
//   lane_idx   : row-major lane number of element (row, col)
//   idx_width  : counter width able to address nn lanes (never below 1)
// ---------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int MM_ORDER    = 2;
    localparam int MM_BITWIDTH = 8;
    localparam int MM_NN       = MM_ORDER * MM_ORDER;
    localparam int MM_FLAT_W   = MM_NN * MM_BITWIDTH;

    function automatic int lane_idx(input int row, input int col, input int order);
        return row * order + col;
    endfunction

    function automatic int idx_width(input int nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

endpackage

// File: rtl/matrix_mult_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// matrix_mult_stream_ctrl_if
// Bundles the element input stream, the result output stream and the flat
// operand/result bus towards one matrix_mult instance.
//   master : controller side (drives s_ready, m_*, mm_reset/enable, mm_a/b)
//   slave  : host + multiplier side (drives s_valid/s_data, m_ready, mm_c/rdy)
// ---------------------------------------------------------------------------
interface matrix_mult_stream_ctrl_if #(
    parameter int ORDER    = mm_pkg::MM_ORDER,
    parameter int BITWIDTH = mm_pkg::MM_BITWIDTH
);
    localparam int FLAT_W = ORDER * ORDER * BITWIDTH;

    // input element stream
    logic                s_valid;
    logic                s_ready;
    logic [BITWIDTH-1:0] s_data;
    // result element stream
    logic                m_valid;
    logic                m_ready;
    logic [BITWIDTH-1:0] m_data;
    logic                m_last;
    // multiplier side
    logic                mm_reset;
    logic                mm_enable;
    logic [FLAT_W-1:0]   mm_a;
    logic [FLAT_W-1:0]   mm_b;
    logic [FLAT_W-1:0]   mm_c;
    logic                mm_rdy;

    modport master (
        input  s_valid, s_data, m_ready, mm_c, mm_rdy,
        output s_ready, m_valid, m_data, m_last, mm_reset, mm_enable, mm_a, mm_b
    );

    modport slave (
        output s_valid, s_data, m_ready, mm_c, mm_rdy,
        input  s_ready, m_valid, m_data, m_last, mm_reset, mm_enable, mm_a, mm_b
    );

endinterface

// File: rtl/matrix_mult_stream_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_mult_stream_ctrl
// Element-serial front/back end for a matrix_mult datapath. Collects A then B
// (row-major, one element per handshake) into flat operand buses, runs the
// multiplier until mm_rdy (or a timeout), captures C and streams it out
// row-major with m_last on the final element.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      stream + multiplier bundle (master modport)
//   err      sticky flag: a job was aborted because mm_rdy never came
// All outputs are registered.
// ---------------------------------------------------------------------------
module matrix_mult_stream_ctrl
    import mm_pkg::*;
#(
    parameter int ORDER    = MM_ORDER,
    parameter int BITWIDTH = MM_BITWIDTH,
    parameter int TIMEOUT  = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    matrix_mult_stream_ctrl_if.master bus,
    output logic                     err
);
    localparam int NN     = ORDER * ORDER;
    localparam int FLAT_W = NN * BITWIDTH;
    localparam int IDXW   = idx_width(NN);
    localparam int WAITW  = idx_width(TIMEOUT);
    localparam logic [IDXW-1:0]  LAST_LANE = IDXW'(NN - 1);
    localparam logic [WAITW-1:0] WAIT_MAX  = WAITW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW-1:0]     odx_q, odx_d;
    logic [WAITW-1:0]    wait_q, wait_d;
    logic [FLAT_W-1:0]   a_q, a_d;
    logic [FLAT_W-1:0]   b_q, b_d;
    logic [FLAT_W-1:0]   res_q, res_d;
    logic                err_q, err_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic [BITWIDTH-1:0] m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic                mm_reset_q, mm_reset_d;
    logic                mm_enable_q, mm_enable_d;

    logic                in_hs;
    logic                out_hs;
    logic [BITWIDTH-1:0] res_lane [NN];

    assign in_hs  = bus.s_valid & s_ready_q;
    assign out_hs = m_valid_q & bus.m_ready;

    // Operand packing: the accepted element lands in the lane named by idx.
    // Result lanes are taken from res_d so the first DRAIN element is
    // available in the same cycle C is captured.
    for (genvar gi = 0; gi < NN; gi++) begin : g_lane
        assign a_d[gi*BITWIDTH +: BITWIDTH] =
            (state_q == LOAD_A && in_hs && idx_q == IDXW'(gi)) ? bus.s_data
                                                                 : a_q[gi*BITWIDTH +: BITWIDTH];
        assign b_d[gi*BITWIDTH +: BITWIDTH] =
            (state_q == LOAD_B && in_hs && idx_q == IDXW'(gi)) ? bus.s_data
                                                                 : b_q[gi*BITWIDTH +: BITWIDTH];
        assign res_lane[gi] = res_d[gi*BITWIDTH +: BITWIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            odx_q       <= '0;
            wait_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            mm_reset_q  <= 1'b1;
            mm_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            odx_q       <= odx_d;
            wait_q      <= wait_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            err_q       <= err_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            mm_reset_q  <= mm_reset_d;
            mm_enable_q <= mm_enable_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        odx_d   = odx_q;
        wait_d  = wait_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            LOAD_A: begin
                if (in_hs) begin
                    if (idx_q == LAST_LANE) begin
                        state_d = LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    if (idx_q == LAST_LANE) begin
                        state_d = RUN;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                // mm_rdy is tested first so a result arriving on the
                // timeout cycle is still delivered without raising err.
                if (bus.mm_rdy) begin
                    res_d   = bus.mm_c;
                    odx_d   = '0;
                    state_d = DRAIN;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = LOAD_A;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (odx_q == LAST_LANE) begin
                        state_d = LOAD_A;
                        odx_d   = '0;
                    end else begin
                        odx_d = odx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        s_ready_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
        mm_enable_d = (state_d == RUN);
        mm_reset_d  = (state_d != RUN);
        m_valid_d   = (state_d == DRAIN);
        m_last_d    = (state_d == DRAIN) && (odx_d == LAST_LANE);
        m_data_d    = (state_d == DRAIN) ? res_lane[odx_d] : '0;
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;
    assign bus.mm_reset  = mm_reset_q;
    assign bus.mm_enable = mm_enable_q;
    assign bus.mm_a      = a_q;
    assign bus.mm_b      = b_q;
    assign err           = err_q;

endmodule
